// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler beside the E stage of the 5-stage MIPS pipeline.
// Owns HI/LO, models the fixed mult/div latency with a countdown and raises
// stall_md while a D-stage HI/LO-related instruction has to wait.
// Optional feature macro: MD_ZERO_BYPASS_EN (mult/multu with a zero operand
// completes in one cycle).
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0]       cnt_reg;
  logic [31:0]         hi_reg;
  logic [31:0]         lo_reg;
  logic [31:0]         hi_n;
  logic [31:0]         lo_n;
  logic                commit_reg;

  logic signed [63:0]  prod_s;
  logic [63:0]         prod_u;
  logic [31:0]         div_b;
  logic signed [31:0]  quo_s;
  logic signed [31:0]  rem_s;
  logic [31:0]         quo_u;
  logic [31:0]         rem_u;
  logic [31:0]         hi_calc;
  logic [31:0]         lo_calc;
  logic [CW-1:0]       cnt_load;
  logic                div_zero;

  // Compute the result of the issuing operation and the countdown it needs.
  always_comb begin
    prod_s   = $signed(A) * $signed(B);
    prod_u   = {32'd0, A} * {32'd0, B};
    // A zero divisor is replaced by 1 so the dividers never produce X;
    // the result is discarded anyway.
    div_b    = (B == 32'd0) ? 32'd1 : B;
    quo_s    = $signed(A) / $signed(div_b);
    rem_s    = $signed(A) % $signed(div_b);
    quo_u    = A / div_b;
    rem_u    = A % div_b;
    div_zero = md_op[1] && (B == 32'd0);
    hi_calc  = 32'd0;
    lo_calc  = 32'd0;
    cnt_load = md_op[1] ? DIV_LOAD : MULT_LOAD;
    case (md_op)
      2'b00: begin hi_calc = prod_s[63:32]; lo_calc = prod_s[31:0]; end
      2'b01: begin hi_calc = prod_u[63:32]; lo_calc = prod_u[31:0]; end
      2'b10: begin hi_calc = rem_s;         lo_calc = quo_s;        end
      default: begin hi_calc = rem_u;       lo_calc = quo_u;        end
    endcase
`ifdef MD_ZERO_BYPASS_EN
    if (!md_op[1] && (A == 32'd0 || B == 32'd0)) begin
      cnt_load = ONE;
      hi_calc  = 32'd0;
      lo_calc  = 32'd0;
    end
`endif
  end

  // Countdown, pending-result capture and HI/LO architectural updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      hi_n       <= 32'd0;
      lo_n       <= 32'd0;
      commit_reg <= 1'b0;
    end else if (cnt_reg == '0) begin
      if (start) begin
        cnt_reg    <= cnt_load;
        hi_n       <= hi_calc;
        lo_n       <= lo_calc;
        commit_reg <= !div_zero;
      end else begin
        if (mthi) hi_reg <= A;
        if (mtlo) lo_reg <= A;
      end
    end else begin
      cnt_reg <= cnt_reg - ONE;
      if (cnt_reg == ONE && commit_reg) begin
        hi_reg <= hi_n;
        lo_reg <= lo_n;
      end
    end
  end

  assign busy     = (cnt_reg != '0);
  assign stall_md = md_use_D & (start | busy);
  assign HI       = hi_reg;
  assign LO       = lo_reg;

`ifndef SYNTHESIS
  // The hazard unit must never issue mult/div or mthi/mtlo while busy.
  a_no_issue_busy: assert property (@(posedge clk) disable iff (reset)
    busy |-> !(start || mthi || mtlo));
`endif

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed test-plan scenarios with literal
// expectations, then randomized traffic checked each cycle against a
// schedule-based model (completion edge + pending result).
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        md_use_D = 1'b0;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int failures = 0;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .md_use_D(md_use_D),
    .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The unit is busy in every cycle following edge e while e < done_edge;
  // a pending result lands on edge done_edge.
  int          edge_n = 0;
  int          done_edge = 0;
  bit          pend = 0;
  logic [31:0] p_hi, p_lo;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic bit model_busy();
    return edge_n < done_edge;
  endfunction

  task automatic compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output bit ok, output int lat);
    longint sa, sb, q, r, qa;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1; rh = 0; rl = 0;
    lat = op[1] ? DIV_N : MULT_N;
    case (op)
      2'b00: begin q = sa * sb; rh = q[63:32]; rl = q[31:0]; end
      2'b01: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      2'b10: begin
        if (b == 0) ok = 0;
        else begin
          qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
          q  = ((sa < 0) != (sb < 0)) ? -qa : qa;
          r  = sa - q * sb;
          rl = q[31:0]; rh = r[31:0];
        end
      end
      default: begin
        if (b == 0) ok = 0;
        else begin up = ua / ub; rl = up[31:0]; up = ua - up * ub; rh = up[31:0]; end
      end
    endcase
`ifdef MD_ZERO_BYPASS_EN
    if (!op[1] && (a == 0 || b == 0)) begin lat = 1; rh = 0; rl = 0; end
`endif
  endtask

  always @(posedge clk) begin
    logic [31:0] th, tl;
    bit tok;
    int tlat;
    edge_n++;
    if (reset) begin
      done_edge = edge_n; pend = 0; m_hi = 0; m_lo = 0;
    end else if (edge_n == done_edge) begin
      if (pend) begin m_hi = p_hi; m_lo = p_lo; end
      pend = 0;
    end else if (edge_n - 1 >= done_edge) begin
      if (start) begin
        compute(md_op, A, B, th, tl, tok, tlat);
        p_hi = th; p_lo = tl; pend = tok;
        done_edge = edge_n + tlat;
      end else begin
        if (mthi) m_hi = A;
        if (mtlo) m_lo = A;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = md_use_D & (start | model_busy());
    checks++;
    if (busy !== model_busy() || stall_md !== exp_stall || HI !== m_hi || LO !== m_lo) begin
      failures++;
      $display("FAIL model t=%0t busy=%b/%b stall=%b/%b HI=%h/%h LO=%h/%h (actual/required)",
               $time, busy, model_busy(), stall_md, exp_stall, HI, m_hi, LO, m_lo);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  // Issue one operation and follow it until busy drops (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit use_d, input bit with_mtlo, output int bcnt, output int scnt);
    @(posedge clk); #1;
    start = 1; md_op = op; A = a; B = b; mtlo = with_mtlo; md_use_D = use_d;
    bcnt = 0; scnt = 0;
    @(negedge clk);
    if (stall_md) scnt++;
    @(posedge clk); #1;
    start = 0; mtlo = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      bcnt++;
      if (stall_md) scnt++;
    end
    md_use_D = 0;
    $display("op=%0d A=%h B=%h busy_cycles=%0d stall_cycles=%0d HI=%h LO=%h",
             op, a, b, bcnt, scnt, HI, LO);
  endtask

  initial begin
    int bc, sc;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_HI", HI, 32'd0);
    check("reset_LO", LO, 32'd0);

    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 0, 0, bc, sc);
    check("mult_busy_cycles", bc, 32'd5);
    check("mult_HI", HI, 32'hFFFFFFFF);
    check("mult_LO", LO, 32'hFFFFFFFA);

    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 0, 0, bc, sc);
    check("multu_HI", HI, 32'h00000001);
    check("multu_LO", LO, 32'hFFFFFFFE);

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1, 0, bc, sc);
    check("div_busy_cycles", bc, 32'd10);
    check("div_stall_cycles", sc, 32'd11);
    check("div_HI", HI, 32'hFFFFFFFF);
    check("div_LO", LO, 32'hFFFFFFFD);
    check("stall_after_div", {31'd0, stall_md}, 32'd0);

    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, 0, bc, sc);
    check("divu_stall_cycles", sc, 32'd0);
    check("divu_HI", HI, 32'h00000001);
    check("divu_LO", LO, 32'h7FFFFFFC);

    @(posedge clk); #1;
    mthi = 1; A = 32'h12345678;
    @(posedge clk); #1;
    mthi = 0;
    @(negedge clk);
    check("mthi_HI", HI, 32'h12345678);

    run_op(2'b00, 32'd4, 32'd5, 0, 1, bc, sc);
    check("start_over_mtlo_LO", LO, 32'd20);
    check("start_over_mtlo_HI", HI, 32'd0);

    run_op(2'b10, 32'd77, 32'd0, 0, 0, bc, sc);
    check("divzero_busy_cycles", bc, 32'd10);
    check("divzero_HI", HI, 32'd0);
    check("divzero_LO", LO, 32'd20);

    // Reset while cnt==3 during a mult.
    @(posedge clk); #1;
    start = 1; md_op = 2'b00; A = 32'd7; B = 32'd9;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_LO", LO, 32'd0);
    $display("mid-op reset: busy=%b HI=%h LO=%h", busy, HI, LO);

`ifdef MD_ZERO_BYPASS_EN
    run_op(2'b00, 32'd123, 32'd0, 0, 0, bc, sc);
    check("bypass_busy_cycles", bc, 32'd1);
    check("bypass_HI", HI, 32'd0);
    check("bypass_LO", LO, 32'd0);
`endif

    // Randomized traffic; the model + compare process do the checking.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = 0; mthi = 0; mtlo = 0;
      md_use_D = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: ra = 32'd0;
        1: ra = $urandom_range(0, 20) - 10;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(0, 20) - 10;
        default: rb = $urandom;
      endcase
      md_op = 2'($urandom_range(0, 3));
      if (md_op == 2'b10 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      A = ra; B = rb;
      if (!model_busy()) begin
        start = ($urandom_range(0, 9) < 3);
        mthi  = ($urandom_range(0, 9) < 2);
        mtlo  = ($urandom_range(0, 9) < 2);
        if (start) $display("rand issue op=%0d A=%h B=%h mthi=%b mtlo=%b", md_op, ra, rb, mthi, mtlo);
      end
    end
    @(posedge clk); #1;
    start = 0; mthi = 0; mtlo = 0; md_use_D = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
